instruction_fetch: RTL and testbench

Instruction fetch stage of the 32-bit RISC-V core, directly upstream of `Instruction_decode`. It holds the PC and issues word requests to instruction memory over a valid/ready request channel, with at most one request outstanding. It presents fetched words plus their PC to decode through a stallable IF/ID output register backed by a one-entry skid buffer. It redirects on taken branches and jumps, discarding wrong-path fetches.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/if_skid_buffer.sv | 61 ++++++
 rtl/instruction_fetch.sv | 156 +++++++++++++++
 tb/tb_instruction_fetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end.
//   XLEN             : datapath width
//   INSN_NOP         : canonical NOP (addi x0,x0,0), the IF/ID reset contents
//   RESET_PC_DEFAULT : default boot PC
//   fetch_state_t    : fetch FSM states
//   word_align()     : clears the byte-offset bits of an address
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSN_NOP         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,  // ready to issue a request
        S_WAIT  = 2'd1,  // request accepted, response pending
        S_FLUSH = 2'd2   // response pending but belongs to a squashed path
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {instruction, pc} holding register placed behind the IF/ID register.
// Absorbs the single outstanding fetch response when decode is stalled.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   load_i              : capture instr_i/pc_i (caller guarantees entry is empty)
//   drain_i             : entry has been moved into IF/ID, mark empty
//   clear_i             : squash the entry (redirect); wins over load/drain
//   instr_i, pc_i       : word and its PC to capture
//   full_o              : entry holds valid data
//   instr_o, pc_o       : stored word and PC
module if_skid_buffer
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            drain_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            full_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic            full_q,  full_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q,    pc_d;

    always_comb begin
        full_d  = full_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d  = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            instr_q <= INSN_NOP;
            pc_q    <= '0;
        end else begin
            full_q  <= full_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign full_o  = full_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues one word request at a time to
// instruction memory, and presents fetched words to decode through a stallable
// IF/ID register backed by a one-entry skid buffer. Redirects squash wrong-path
// fetches, including a response still in flight.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   imem_req_valid/ready, imem_addr : request channel (addr is word aligned)
//   imem_rsp_valid, imem_rsp_data   : response, must be taken on arrival
//   redirect_valid, redirect_pc     : taken branch / jump target
//   stall                           : decode cannot accept this cycle
//   if_valid, if_instruction, if_pc : IF/ID register contents
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instruction,
    output logic [XLEN-1:0] if_pc
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;

    logic            skid_full;
    logic [XLEN-1:0] skid_instr, skid_pc;
    logic            skid_load, skid_drain, skid_clear;

    logic            req_hs;
    logic            rsp_take;

    // Requests are held off while the skid is occupied so that a response can
    // always be absorbed somewhere without a ready signal on the return path.
    assign imem_req_valid = (state_q == S_REQ) && !skid_full;
    assign imem_addr      = word_align(pc_q);
    assign req_hs         = imem_req_valid && imem_req_ready;
    // A response is only delivered to decode if it is on the current path.
    assign rsp_take       = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        skid_load     = 1'b0;
        skid_drain    = 1'b0;
        skid_clear    = 1'b0;

        case (state_q)
            S_REQ: begin
                if (req_hs) begin
                    state_d       = S_WAIT;
                    inflight_pc_d = pc_q;
                    pc_d          = pc_q + 32'd4;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) state_d = S_REQ;
            end
            S_FLUSH: begin
                if (imem_rsp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        // Decode consumes the IF/ID entry; refill from the skid first so the
        // older word always reaches decode before a newer response.
        if (!stall) begin
            if (skid_full) begin
                if_valid_d = 1'b1;
                if_instr_d = skid_instr;
                if_pc_d    = skid_pc;
                skid_drain = 1'b1;
            end else begin
                if_valid_d = 1'b0;
            end
        end

        // Skid can only be full while no request is outstanding, so a response
        // never coincides with a skid drain.
        if (rsp_take) begin
            if (if_valid_q && stall) begin
                skid_load = 1'b1;
            end else begin
                if_valid_d = 1'b1;
                if_instr_d = imem_rsp_data;
                if_pc_d    = inflight_pc_q;
            end
        end

        if (redirect_valid) begin
            pc_d       = word_align(redirect_pc);
            if_valid_d = 1'b0;
            skid_clear = 1'b1;
            case (state_q)
                // A request accepted this edge went to the old address.
                S_REQ:   state_d = req_hs ? S_FLUSH : S_REQ;
                S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_FLUSH;
                S_FLUSH: state_d = imem_rsp_valid ? S_REQ : S_FLUSH;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= INSN_NOP;
            if_pc_q       <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
        end
    end

    if_skid_buffer u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .instr_i (imem_rsp_data),
        .pc_i    (inflight_pc_q),
        .full_o  (skid_full),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    assign if_valid       = if_valid_q;
    assign if_instruction = if_instr_q;
    assign if_pc          = if_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch. A program-order model tracks the next PC to be
// requested and the next PC decode must receive; a memory model answers each
// request after a chosen latency. Directed phases pin the model with literal
// expectations; a randomised tail exercises mixed stall/ready/redirect.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instruction, if_pc;

    logic        w_req_valid, w_req_ready, w_rsp_valid, w_if_valid;
    logic [31:0] w_addr, w_rsp_data, w_if_instruction, w_if_pc;
    logic        w_redirect_valid, w_stall;
    logic [31:0] w_redirect_pc;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .if_valid(if_valid), .if_instruction(if_instruction), .if_pc(if_pc)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc), .stall(w_stall),
        .if_valid(w_if_valid), .if_instruction(w_if_instruction), .if_pc(w_if_pc)
    );

    int n_chk = 0;
    int n_fail = 0;

    // model state
    logic [31:0] req_pc, exp_pc;
    int          hs_cnt, cons_cnt;
    logic [31:0] hs_addr[$];
    logic        mem_pend;
    int          mem_cnt, mem_lat;
    logic [31:0] mem_addr;
    logic        redir_prev, hold_prev;
    logic [31:0] hold_pc, hold_insn;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_0F03;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        req_pc = 32'h0; exp_pc = 32'h0;
        hs_cnt = 0; cons_cnt = 0; hs_addr.delete();
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0;
        redir_prev = 1'b0; hold_prev = 1'b0;
    endtask

    // Called at a negedge: checks settled outputs, drives inputs for the next
    // rising edge, advances the model across that edge, returns at next negedge.
    task automatic step(input logic rdy, input logic st, input logic rv, input logic [31:0] rpc);
        if (redir_prev) chk("if_valid after redirect", {31'b0, if_valid}, 32'd0);
        if (hold_prev) begin
            chk("stalled if_valid held", {31'b0, if_valid}, 32'd1);
            chk("stalled if_pc held", if_pc, hold_pc);
            chk("stalled if_instruction held", if_instruction, hold_insn);
        end
        if (mem_pend) chk("no request while outstanding", {31'b0, imem_req_valid}, 32'd0);
        if (imem_req_valid) chk("imem_addr tracks pc", imem_addr, req_pc);

        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
        if (mem_pend) begin
            if (mem_cnt <= 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memf(mem_addr);
                mem_pend = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        imem_req_ready = rdy;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;

        if (if_valid && !st && !rv) begin
            chk("consumed if_pc", if_pc, exp_pc);
            chk("consumed if_instruction", if_instruction, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            cons_cnt++;
        end
        hold_prev = if_valid && st && !rv;
        hold_pc   = if_pc;
        hold_insn = if_instruction;

        if (imem_req_valid && rdy) begin
            hs_addr.push_back(imem_addr);
            hs_cnt++;
            req_pc   = req_pc + 32'd4;
            mem_pend = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = imem_addr;
        end
        if (rv) begin
            req_pc = {rpc[31:2], 2'b00};
            exp_pc = {rpc[31:2], 2'b00};
        end
        redir_prev = rv;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        redirect_valid = 0; redirect_pc = '0; stall = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " if_valid"}, {31'b0, if_valid}, 32'd0);
        chk({tag, " if_instruction"}, if_instruction, 32'h0000_0013);
        chk({tag, " if_pc"}, if_pc, 32'h0);
        chk({tag, " imem_req_valid"}, {31'b0, imem_req_valid}, 32'd1);
        chk({tag, " imem_addr"}, imem_addr, 32'h0);
    endtask

    initial begin
        w_req_ready = 0; w_rsp_valid = 0; w_rsp_data = '0;
        w_redirect_valid = 0; w_redirect_pc = '0; w_stall = 0;
        mem_lat = 1;
        do_reset();

        // reset state
        chk_reset_vals("reset");
        chk("wrap dut reset if_pc", w_if_pc, 32'hFFFF_FFFC);
        chk("wrap dut reset addr", w_addr, 32'hFFFF_FFFC);

        // sequential fetch, one instruction per two cycles
        repeat (8) step(1, 0, 0, 0);
        chk("seq request count", hs_cnt, 4);
        chk("seq consumed count", cons_cnt, 3);
        chk("seq addr0", hs_addr[0], 32'h0);
        chk("seq addr1", hs_addr[1], 32'h4);
        chk("seq addr2", hs_addr[2], 32'h8);
        chk("seq addr3", hs_addr[3], 32'hC);
        chk("seq last if_pc", if_pc, 32'hC);

        // request backpressure: address holds
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("backpressure addr", imem_addr, 32'h10);
            chk("backpressure req_valid", {31'b0, imem_req_valid}, 32'd1);
        end
        chk("backpressure no handshake", hs_cnt, 4);

        // decode stall fills IF/ID then skid; requests stop
        repeat (6) step(1, 1, 0, 0);
        chk("stall req_valid blocked", {31'b0, imem_req_valid}, 32'd0);
        chk("stall if_pc", if_pc, 32'h10);
        step(1, 0, 0, 0);
        chk("skid drained if_valid", {31'b0, if_valid}, 32'd1);
        chk("skid drained if_pc", if_pc, 32'h14);
        chk("skid drained insn", if_instruction, 32'h5A5A_0F17);
        chk("after drain addr", imem_addr, 32'h18);
        repeat (4) step(1, 0, 0, 0);

        // redirect while waiting for a response
        do_reset();
        mem_lat = 3;
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h100);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("wait-redirect if_valid", {31'b0, if_valid}, 32'd0);
        chk("wait-redirect req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("wait-redirect addr", imem_addr, 32'h100);
        chk("wait-redirect requests", hs_addr.size(), 1);
        mem_lat = 1;
        repeat (6) step(1, 0, 0, 0);
        chk("wait-redirect target fetched", hs_addr[1], 32'h100);
        chk("wait-redirect consumed", cons_cnt, 2);

        // redirect coinciding with handshake, then with a response
        do_reset();
        step(1, 0, 1, 32'h103);
        step(1, 0, 0, 0);
        chk("hs-redirect if_valid", {31'b0, if_valid}, 32'd0);
        chk("hs-redirect req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("hs-redirect addr", imem_addr, 32'h100);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h200);
        chk("rsp-redirect if_valid", {31'b0, if_valid}, 32'd0);
        chk("rsp-redirect req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rsp-redirect addr", imem_addr, 32'h200);
        repeat (4) step(1, 0, 0, 0);
        chk("pre stall-redirect if_pc", if_pc, 32'h204);
        step(1, 1, 1, 32'h40);
        chk("stall-redirect clears if_valid", {31'b0, if_valid}, 32'd0);
        repeat (6) step(1, 0, 0, 0);
        chk("redirect phase consumed", cons_cnt, 3);

        // asynchronous reset while waiting for a response
        mem_lat = 3;
        step(1, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async reset");
        model_reset();
        mem_lat = 1;
        imem_rsp_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1, 0, 0, 0);
        chk("post-reset consumed", cons_cnt, 1);

        // mixed random traffic checked by the model
        for (int i = 0; i < 300; i++) begin
            logic        rr, ss, vv;
            logic [31:0] tgt;
            mem_lat = $urandom_range(1, 3);
            rr  = ($urandom_range(0, 3) != 0);
            ss  = ($urandom_range(0, 3) == 0);
            vv  = ($urandom_range(0, 15) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFF);
            step(rr, ss, vv, tgt);
        end
        chk("random traffic progressed", {31'b0, cons_cnt > 20}, 32'd1);

        // PC wrap on the second instance
        chk("wrap first addr", w_addr, 32'hFFFF_FFFC);
        w_req_ready = 1'b1;
        @(negedge clk);
        w_req_ready = 1'b0;
        chk("wrap waiting req_valid", {31'b0, w_req_valid}, 32'd0);
        w_rsp_valid = 1'b1;
        w_rsp_data  = 32'h1234_5678;
        @(negedge clk);
        w_rsp_valid = 1'b0;
        chk("wrap if_valid", {31'b0, w_if_valid}, 32'd1);
        chk("wrap if_pc", w_if_pc, 32'hFFFF_FFFC);
        chk("wrap if_instruction", w_if_instruction, 32'h1234_5678);
        chk("wrap second addr", w_addr, 32'h0);
        chk("wrap second req_valid", {31'b0, w_req_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
